// File: rtl/locked_reg_bank.sv
// -----------------------------------------------------------------------------
// locked_reg_bank
//
// A bank of NUM_REGS data registers behind a single command port. Each
// register has a sticky lock bit that blocks writes until reset. Writing
// KEY_A and then KEY_B arms an override. The override lasts ARM_WINDOW cycles
// and lets exactly one write through to a locked register. Refused writes and
// bad keys increment a saturating violation counter. A sticky alarm is raised
// when that counter reaches ALARM_THRESH.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   cmd_valid       command present this cycle (always accepted)
//   cmd_op          00 WRITE, 01 LOCK, 10 KEY, 11 reserved
//   cmd_addr        target register for WRITE/LOCK
//   cmd_data        write data or key word
//   resp_valid      one-cycle pulse, the cycle after each command
//   resp_err        command refused or invalid (qualified by resp_valid)
//   rd_addr         read address
//   rd_data         registered read data (0 for out-of-range addresses)
//   lock_status     current lock bits, one per register
//   armed           unlock override is currently armed
//   violation_cnt   saturating violation count
//   alarm           sticky alarm
// -----------------------------------------------------------------------------
module locked_reg_bank #(
    parameter int                NUM_REGS     = 4,
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 2,
    parameter logic [DATA_W-1:0] RESET_VAL    = '0,
    parameter logic [DATA_W-1:0] KEY_A        = 16'hA5C3,
    parameter logic [DATA_W-1:0] KEY_B        = 16'h3C5A,
    parameter int                ARM_WINDOW   = 8,
    parameter int                VCNT_W       = 4,
    parameter int                ALARM_THRESH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                resp_valid,
    output logic                resp_err,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0] lock_status,
    output logic                armed,
    output logic [VCNT_W-1:0]   violation_cnt,
    output logic                alarm
);

    localparam int TMR_W = $clog2(ARM_WINDOW + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GOT_A = 2'b01,
        ST_ARMED = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_LOCK  = 2'b01,
        OP_KEY   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    op_e                 op;
    logic [NUM_REGS-1:0] addr_hit;
    logic                in_range;
    logic                target_locked;
    logic                cmd_err;
    logic                violation;
    logic                wr_en;
    logic                lock_en;
    logic                consume;
    logic [VCNT_W-1:0]   vcnt_d;
    logic [DATA_W-1:0]   rd_next;

    // -------------------------------------------------------------------------
    // Address decode. A one-hot hit vector avoids indexing past NUM_REGS when
    // the address space is larger than the bank.
    // -------------------------------------------------------------------------
    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_hit[i] = (cmd_addr == ADDR_W'(i));
        end
    end

    assign in_range      = |addr_hit;
    assign target_locked = |(addr_hit & lock_status);
    assign op            = op_e'(cmd_op);

    // -------------------------------------------------------------------------
    // Command decode and unlock FSM next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch. Otherwise a path
        // that does not assign it would hold the old value, which infers a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        cmd_err   = 1'b0;
        violation = 1'b0;
        wr_en     = 1'b0;
        lock_en   = 1'b0;
        consume   = 1'b0;

        if (cmd_valid) begin
            unique case (op)
                OP_WRITE: begin
                    if (!in_range) begin
                        cmd_err = 1'b1;
                    end else if (!target_locked) begin
                        wr_en = 1'b1;
                    end else if (state_q == ST_ARMED) begin
                        wr_en   = 1'b1;
                        consume = 1'b1;
                    end else begin
                        cmd_err   = 1'b1;
                        violation = 1'b1;
                    end
                end
                OP_LOCK: begin
                    if (in_range) lock_en = 1'b1;
                    else          cmd_err = 1'b1;
                end
                OP_RSVD: cmd_err = 1'b1;
                default: ; // KEY is resolved by the FSM below
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && op == OP_KEY) begin
                    if (cmd_data == KEY_A) begin
                        state_d = ST_GOT_A;
                    end else begin
                        cmd_err   = 1'b1;
                        violation = 1'b1;
                    end
                end
            end
            ST_GOT_A: begin
                // Idle cycles keep the half-entered sequence alive. Any
                // command other than KEY_B abandons it.
                if (cmd_valid) begin
                    state_d = ST_IDLE;
                    if (op == OP_KEY) begin
                        if (cmd_data == KEY_B) begin
                            state_d = ST_ARMED;
                            timer_d = TMR_W'(ARM_WINDOW);
                        end else begin
                            cmd_err   = 1'b1;
                            violation = 1'b1;
                        end
                    end
                end
            end
            ST_ARMED: begin
                if (cmd_valid && op == OP_KEY) begin
                    // Any key while armed is an explicit disarm.
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                    cmd_err   = 1'b1;
                    violation = 1'b1;
                end else if (consume || timer_q == TMR_W'(1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Saturating violation count. The alarm compares against the updated
    // count, so it rises on the same edge the threshold is reached.
    always_comb begin
        vcnt_d = violation_cnt;
        if (violation && violation_cnt != {VCNT_W{1'b1}}) begin
            vcnt_d = violation_cnt + VCNT_W'(1);
        end
    end

    // Read mux. Out-of-range addresses fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_next = regs_q[i];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample pre-edge values. This is what makes a same-edge write invisible
    // to rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            lock_status   <= '0;
            violation_cnt <= '0;
            alarm         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            rd_data       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            violation_cnt <= vcnt_d;
            alarm         <= alarm | (vcnt_d >= VCNT_W'(ALARM_THRESH));
            resp_valid    <= cmd_valid;
            resp_err      <= cmd_valid & cmd_err;
            rd_data       <= rd_next;
            if (lock_en) lock_status <= lock_status | addr_hit;
        end
    end

    // NOTE: the data registers are a memory that is deliberately reset. Every
    // register must read RESET_VAL after rst_n, so the reset loop is required
    // here, unlike a plain RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && addr_hit[i]) regs_q[i] <= cmd_data;
            end
        end
    end

    assign armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_locked_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_locked_reg_bank
//
// Directed bench for locked_reg_bank. Inputs are driven on the falling edge.
// Each command pushes its expected resp_err into a queue. An independent
// monitor pops that queue whenever resp_valid is seen on a falling edge.
// Architectural state (rd_data, lock_status, armed, violation_cnt, alarm) is
// compared inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_locked_reg_bank;

    localparam logic [1:0] WR = 2'b00;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] KY = 2'b10;
    localparam logic [1:0] RS = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        resp_valid;
    logic        resp_err;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  lock_status;
    logic        armed;
    logic [3:0]  violation_cnt;
    logic        alarm;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit mon_exp;

    locked_reg_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .lock_status   (lock_status),
        .armed         (armed),
        .violation_cnt (violation_cnt),
        .alarm         (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] data,
                        input bit exp_err);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        exp_q.push_back(exp_err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = WR;
            cmd_data  = '0;
        end
    endtask

    // Asynchronous reset pulse away from any clock edge, released on a falling edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_armed", armed, 0);
        check("rst_lock", lock_status, 0);
        check("rst_vcnt", violation_cnt, 0);
        check("rst_alarm", alarm, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: one expectation per resp_valid pulse.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: resp_valid high with no command outstanding at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_err", resp_err, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = WR;
        cmd_addr  = '0;
        cmd_data  = '0;
        rd_addr   = 2'd1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_lock", lock_status, 0);
        check("reset_armed", armed, 0);
        check("reset_vcnt", violation_cnt, 0);
        check("reset_alarm", alarm, 0);
        check("reset_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Plain write; same-edge read shows the old value
        send(WR, 2'd1, 16'h1234, 1'b0);
        idle(1);
        check("rd_same_edge", rd_data, 16'h0000);
        idle(1);
        check("rd_after_write", rd_data, 16'h1234);

        // Lock, then refused write
        send(LK, 2'd1, 16'h0000, 1'b0);
        send(WR, 2'd1, 16'hFFFF, 1'b1);
        idle(1);
        check("vcnt_locked_write", violation_cnt, 1);
        check("lock_after_lock", lock_status, 4'b0010);
        idle(1);
        check("rd_locked_kept", rd_data, 16'h1234);

        // Key sequence and single-use override
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        send(KY, 2'd0, 16'h3C5A, 1'b0);
        idle(1);
        check("armed_after_key_b", armed, 1);
        send(WR, 2'd1, 16'hBEEF, 1'b0);
        idle(1);
        check("armed_consumed", armed, 0);
        check("lock_kept", lock_status, 4'b0010);
        idle(1);
        check("rd_override_write", rd_data, 16'hBEEF);
        send(WR, 2'd1, 16'h1111, 1'b1);
        idle(1);
        check("vcnt_repeat_write", violation_cnt, 2);
        check("alarm_below_thresh", alarm, 0);

        // Window expiry: armed after E..E+7, cleared after E+8, write at E+9 refused
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        send(KY, 2'd0, 16'h3C5A, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            idle(1);
            check($sformatf("armed_window_%0d", i), armed, (i < 8) ? 1 : 0);
        end
        send(WR, 2'd1, 16'h2222, 1'b1);
        idle(1);
        check("vcnt_expired", violation_cnt, 3);
        check("alarm_at_thresh", alarm, 1);
        idle(1);
        check("rd_expired_kept", rd_data, 16'hBEEF);

        // Write sampled at E+8 still uses the override
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        send(KY, 2'd0, 16'h3C5A, 1'b0);
        idle(7);
        send(WR, 2'd1, 16'h5555, 1'b0);
        idle(1);
        check("armed_last_cycle_used", armed, 0);
        idle(1);
        check("rd_last_cycle_write", rd_data, 16'h5555);

        // Fresh start for the violation counter
        pulse_reset();
        idle(1);
        check("rd_reset_val", rd_data, 16'h0000);

        for (int i = 1; i <= 3; i++) begin
            send(KY, 2'd0, 16'h0000, 1'b1);
            idle(1);
            check($sformatf("vcnt_bad_key_%0d", i), violation_cnt, i);
            check($sformatf("alarm_bad_key_%0d", i), alarm, (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 20; i++) send(KY, 2'd0, 16'h0000, 1'b1);
        idle(1);
        check("vcnt_saturated", violation_cnt, 15);
        check("alarm_sticky", alarm, 1);

        // GOT_A survives idle cycles; LOCK does not consume the override
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        idle(3);
        send(KY, 2'd0, 16'h3C5A, 1'b0);
        idle(1);
        check("armed_after_idle_got_a", armed, 1);
        send(LK, 2'd2, 16'h0000, 1'b0);
        send(WR, 2'd2, 16'h7777, 1'b0);
        idle(1);
        check("armed_after_lock_write", armed, 0);
        check("lock_reg2", lock_status, 4'b0100);
        rd_addr = 2'd2;
        idle(1);
        check("rd_reg2", rd_data, 16'h7777);

        // Key while armed disarms
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        send(KY, 2'd0, 16'h3C5A, 1'b0);
        send(KY, 2'd0, 16'h1234, 1'b1);
        idle(1);
        check("armed_disarm", armed, 0);

        // Reserved op aborts GOT_A
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        send(RS, 2'd0, 16'h0000, 1'b1);
        send(KY, 2'd0, 16'h3C5A, 1'b1);
        idle(1);
        check("armed_rsvd_abort", armed, 0);

        // Reset in the middle of the key sequence
        send(KY, 2'd0, 16'hA5C3, 1'b0);
        idle(1);
        pulse_reset();
        send(KY, 2'd0, 16'h3C5A, 1'b1);
        idle(1);
        check("armed_after_reset_key_b", armed, 0);
        check("vcnt_after_reset_key_b", violation_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            idle(1);
            check($sformatf("rd_reset_reg%0d", i), rd_data, 16'h0000);
        end

        // Reserved op is not a violation
        send(RS, 2'd1, 16'h0000, 1'b1);
        idle(1);
        check("vcnt_rsvd", violation_cnt, 1);
        check("lock_after_reset", lock_status, 0);

        idle(3);
        check("pending_resps", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
